// File: rtl/status_frame_parser_if.sv
// Byte stream from uart_rx into the STATUS frame parser.
interface status_frame_parser_if;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (output rx_valid, output rx_data);
    modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/status_frame_parser.sv
// Motor-board STATUS frame receiver: magic hunt, 26-byte body capture, CRC16 and id check.
// Optional inter-byte gap abort is enabled by defining STATUS_PARSER_TIMEOUT_EN.
module status_frame_parser #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int BAUDRATE         = 115200,
    parameter int TIMEOUT_BYTES    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    status_frame_parser_if.slave        rx_bus,
    input  logic [7:0]                  expected_motor,
    output logic                        frame_valid,
    output logic [7:0]                  motor_id,
    output logic [7:0]                  control_mode,
    output logic signed [31:0]          encoder0_position,
    output logic signed [31:0]          encoder1_position,
    output logic signed [31:0]          encoder0_velocity,
    output logic signed [31:0]          encoder1_velocity,
    output logic [15:0]                 current_phase1,
    output logic [15:0]                 current_phase2,
    output logic [15:0]                 current_phase3,
    output logic                        crc_error,
    output logic                        id_error,
    output logic                        timeout_error,
    output logic [15:0]                 good_frames,
    output logic [15:0]                 crc_errors
);
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        RECEIVE = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [31:0] MAGIC     = 32'h1CEB_00DA;
    localparam logic [4:0]  CRC_BYTES = 5'd24;
    localparam logic [4:0]  BODY_LAST = 5'd25;

`ifdef STATUS_PARSER_TIMEOUT_EN
    localparam int GAP_RELOAD = TIMEOUT_BYTES * 10 * (CLK_FREQ_HZ / BAUDRATE);
    localparam int GAP_W      = $clog2(GAP_RELOAD + 1);
    logic [GAP_W-1:0] gap_r;
`endif

    // x^16+x^15+x^2+1, MSB-first, one byte per call
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_r;
    logic [31:0] hunt_r;
    logic [4:0]  count_r;
    logic [15:0] crc_r;
    logic [7:0]  body_r [0:25];
    logic        crc_ok_s;
    logic        id_ok_s;

    assign crc_ok_s = (crc_r == {body_r[24], body_r[25]});
    assign id_ok_s  = ({24'd0, body_r[0]} < NUMBER_OF_MOTORS) && (body_r[0] == expected_motor);

`ifndef STATUS_PARSER_TIMEOUT_EN
    assign timeout_error = 1'b0;
`endif

    // Frame state machine with registered decoded outputs, strobes and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= HUNT;
            hunt_r            <= 32'h0000_0000;
            count_r           <= 5'd0;
            crc_r             <= 16'hFFFF;
            for (int i = 0; i < 26; i++) begin
                body_r[i] <= 8'h00;
            end
            frame_valid       <= 1'b0;
            motor_id          <= 8'h00;
            control_mode      <= 8'h00;
            encoder0_position <= 32'sd0;
            encoder1_position <= 32'sd0;
            encoder0_velocity <= 32'sd0;
            encoder1_velocity <= 32'sd0;
            current_phase1    <= 16'h0000;
            current_phase2    <= 16'h0000;
            current_phase3    <= 16'h0000;
            crc_error         <= 1'b0;
            id_error          <= 1'b0;
            good_frames       <= 16'h0000;
            crc_errors        <= 16'h0000;
`ifdef STATUS_PARSER_TIMEOUT_EN
            gap_r             <= {GAP_W{1'b0}};
            timeout_error     <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            crc_error   <= 1'b0;
            id_error    <= 1'b0;
`ifdef STATUS_PARSER_TIMEOUT_EN
            timeout_error <= 1'b0;
`endif
            case (state_r)
                HUNT: begin
                    if (hunt_r == MAGIC) begin
                        count_r <= 5'd0;
                        crc_r   <= 16'hFFFF;
                        state_r <= RECEIVE;
`ifdef STATUS_PARSER_TIMEOUT_EN
                        gap_r   <= GAP_W'(GAP_RELOAD);
`endif
                    end else if (rx_bus.rx_valid) begin
                        hunt_r <= {hunt_r[23:0], rx_bus.rx_data};
                    end
                end
                RECEIVE: begin
                    if (rx_bus.rx_valid) begin
                        body_r[count_r] <= rx_bus.rx_data;
                        count_r         <= count_r + 5'd1;
                        if (count_r < CRC_BYTES) begin
                            crc_r <= crc16_step(crc_r, rx_bus.rx_data);
                        end
                        if (count_r == BODY_LAST) begin
                            state_r <= CHECK;
                        end
`ifdef STATUS_PARSER_TIMEOUT_EN
                        gap_r <= GAP_W'(GAP_RELOAD);
                    end else if (gap_r == {GAP_W{1'b0}}) begin
                        state_r       <= HUNT;
                        hunt_r        <= 32'h0000_0000;
                        timeout_error <= 1'b1;
                    end else begin
                        gap_r <= gap_r - GAP_W'(1);
`endif
                    end
                end
                CHECK: begin
                    // A byte arriving now starts the next hunt rather than being lost
                    hunt_r  <= rx_bus.rx_valid ? {24'h000000, rx_bus.rx_data} : 32'h0000_0000;
                    state_r <= HUNT;
                    if (!crc_ok_s) begin
                        crc_error  <= 1'b1;
                        crc_errors <= sat_inc(crc_errors);
                    end else if (!id_ok_s) begin
                        id_error <= 1'b1;
                    end else begin
                        motor_id          <= body_r[0];
                        control_mode      <= body_r[1];
                        encoder0_position <= {body_r[2],  body_r[3],  body_r[4],  body_r[5]};
                        encoder1_position <= {body_r[6],  body_r[7],  body_r[8],  body_r[9]};
                        encoder0_velocity <= {body_r[10], body_r[11], body_r[12], body_r[13]};
                        encoder1_velocity <= {body_r[14], body_r[15], body_r[16], body_r[17]};
                        current_phase1    <= {body_r[18], body_r[19]};
                        current_phase2    <= {body_r[20], body_r[21]};
                        current_phase3    <= {body_r[22], body_r[23]};
                        frame_valid       <= 1'b1;
                        good_frames       <= sat_inc(good_frames);
                    end
                end
                default: begin
                    state_r <= HUNT;
                    hunt_r  <= 32'h0000_0000;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_status_frame_parser.sv
// Directed self-checking bench for status_frame_parser (default and STATUS_PARSER_TIMEOUT_EN builds).
module tb_status_frame_parser;
    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         expected_motor;
    logic               frame_valid;
    logic [7:0]         motor_id;
    logic [7:0]         control_mode;
    logic signed [31:0] encoder0_position;
    logic signed [31:0] encoder1_position;
    logic signed [31:0] encoder0_velocity;
    logic signed [31:0] encoder1_velocity;
    logic [15:0]        current_phase1;
    logic [15:0]        current_phase2;
    logic [15:0]        current_phase3;
    logic               crc_error;
    logic               id_error;
    logic               timeout_error;
    logic [15:0]        good_frames;
    logic [15:0]        crc_errors;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    int ce_cnt   = 0;
    int ie_cnt   = 0;
    int te_cnt   = 0;
    logic [7:0] fr [30];

    // 4 byte times * 10 bits * floor(50e6 / 115200) = 4 * 10 * 434
    localparam int GAP_CYCLES = 17360;

    status_frame_parser_if bus ();

    status_frame_parser dut (
        .clk               (clk),
        .reset             (reset),
        .rx_bus            (bus),
        .expected_motor    (expected_motor),
        .frame_valid       (frame_valid),
        .motor_id          (motor_id),
        .control_mode      (control_mode),
        .encoder0_position (encoder0_position),
        .encoder1_position (encoder1_position),
        .encoder0_velocity (encoder0_velocity),
        .encoder1_velocity (encoder1_velocity),
        .current_phase1    (current_phase1),
        .current_phase2    (current_phase2),
        .current_phase3    (current_phase3),
        .crc_error         (crc_error),
        .id_error          (id_error),
        .timeout_error     (timeout_error),
        .good_frames       (good_frames),
        .crc_errors        (crc_errors)
    );

    always #5 clk = ~clk;

    // Strobe counters: at each edge the value held during the previous cycle is seen
    always @(posedge clk) begin
        if (frame_valid)   fv_cnt++;
        if (crc_error)     ce_cnt++;
        if (id_error)      ie_cnt++;
        if (timeout_error) te_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference CRC: whole byte xored into the top, then eight shift/reduce steps
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) begin
            r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        end
        return r;
    endfunction

    task automatic build_frame(input logic [7:0] id, input logic [7:0] mode,
                               input logic [31:0] e0p, input logic [31:0] e1p,
                               input logic [31:0] e0v, input logic [31:0] e1v,
                               input logic [15:0] c1, input logic [15:0] c2,
                               input logic [15:0] c3, input logic [7:0] crc_flip);
        logic [15:0] c;
        fr[0] = 8'h1C; fr[1] = 8'hEB; fr[2] = 8'h00; fr[3] = 8'hDA;
        fr[4] = id;    fr[5] = mode;
        for (int i = 0; i < 4; i++) begin
            fr[6 + i]  = e0p[31 - 8 * i -: 8];
            fr[10 + i] = e1p[31 - 8 * i -: 8];
            fr[14 + i] = e0v[31 - 8 * i -: 8];
            fr[18 + i] = e1v[31 - 8 * i -: 8];
        end
        fr[22] = c1[15:8]; fr[23] = c1[7:0];
        fr[24] = c2[15:8]; fr[25] = c2[7:0];
        fr[26] = c3[15:8]; fr[27] = c3[7:0];
        c = 16'hFFFF;
        for (int i = 4; i < 28; i++) c = crc_step(c, fr[i]);
        fr[28] = c[15:8];
        fr[29] = c[7:0] ^ crc_flip;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bytes(input int first, input int last, input int last_gap);
        for (int i = first; i <= last; i++) send_byte(fr[i], (i == last) ? last_gap : 2);
    endtask

    initial begin
        int fv0;
        int ce0;
        int ie0;
        int exp_ce;
        int waited;
        logic [15:0] mc;

        reset          = 1'b1;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        expected_motor = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_motor_id", motor_id, 0);
        check("rst_enc0_pos", encoder0_position, 0);
        check("rst_good_frames", good_frames, 0);
        check("rst_crc_errors", crc_errors, 0);
        check("rst_strobes", {crc_error, id_error, timeout_error}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: valid frame
        expected_motor = 8'd2;
        build_frame(8'd2, 8'h05, 32'h0000_1234, 32'h0, 32'h0, 32'hFFFF_FFFE,
                    16'h0100, 16'h0000, 16'h0000, 8'h00);
        send_bytes(0, 29, 0);
        @(negedge clk);
        check("t1_frame_valid", frame_valid, 1);
        check("t1_motor_id", motor_id, 2);
        check("t1_control_mode", control_mode, 8'h05);
        check("t1_enc0_pos", encoder0_position, 32'h0000_1234);
        check("t1_enc1_vel", encoder1_velocity, 32'hFFFF_FFFE);
        check("t1_cur1", current_phase1, 16'h0100);
        check("t1_good_frames", good_frames, 1);
        check("t1_err_strobes", {crc_error, id_error}, 0);
        @(negedge clk);
        check("t1_fv_one_cycle", frame_valid, 0);
        repeat (2) @(negedge clk);

        // 2: corrupted CRC low byte
        build_frame(8'd2, 8'h05, 32'h0000_1234, 32'h0, 32'h0, 32'hFFFF_FFFE,
                    16'h0100, 16'h0000, 16'h0000, 8'h01);
        send_bytes(0, 29, 0);
        @(negedge clk);
        check("t2_crc_error", crc_error, 1);
        check("t2_frame_valid", frame_valid, 0);
        check("t2_crc_errors", crc_errors, 1);
        check("t2_good_frames", good_frames, 1);
        check("t2_enc0_hold", encoder0_position, 32'h0000_1234);
        @(negedge clk);
        check("t2_crc_one_cycle", crc_error, 0);
        repeat (2) @(negedge clk);

        // 3: noise whose tail already forms the magic, so the real frame is swallowed as payload
        expected_motor = 8'd0;
        build_frame(8'd0, 8'h01, 32'hFFFF_FF00, 32'h0000_0010, 32'h0000_0001, 32'h0000_0002,
                    16'h0200, 16'h0300, 16'h0400, 8'h00);
        mc = 16'hFFFF;
        for (int i = 0; i < 24; i++) mc = crc_step(mc, fr[i]);
        exp_ce = (mc != {fr[24], fr[25]}) ? 1 : 0;
        fv0 = fv_cnt; ce0 = ce_cnt; ie0 = ie_cnt;
        send_byte(8'h1C, 2); send_byte(8'hEB, 2); send_byte(8'h00, 2);
        send_byte(8'h1C, 2); send_byte(8'hEB, 2); send_byte(8'h00, 2);
        send_byte(8'hDA, 2);
        send_bytes(0, 29, 2);
        send_bytes(0, 29, 0);
        @(negedge clk);
        check("t3_frame_valid", frame_valid, 1);
        check("t3_enc0_pos", encoder0_position, 32'hFFFF_FF00);
        check("t3_cur3", current_phase3, 16'h0400);
        repeat (2) @(negedge clk);
        check("t3_fv_count", fv_cnt - fv0, 1);
        check("t3_crc_err_count", ce_cnt - ce0, exp_ce);
        check("t3_id_err_count", ie_cnt - ie0, 1 - exp_ce);

        // 4: id out of range, then id != expected_motor
        expected_motor = 8'd7;
        build_frame(8'd7, 8'h02, 32'h1, 32'h2, 32'h3, 32'h4, 16'h1, 16'h2, 16'h3, 8'h00);
        send_bytes(0, 29, 0);
        @(negedge clk);
        check("t4a_id_error", id_error, 1);
        check("t4a_fv_crc", {frame_valid, crc_error}, 0);
        check("t4a_motor_id_hold", motor_id, 0);
        repeat (2) @(negedge clk);
        expected_motor = 8'd3;
        build_frame(8'd1, 8'h02, 32'h1, 32'h2, 32'h3, 32'h4, 16'h1, 16'h2, 16'h3, 8'h00);
        send_bytes(0, 29, 0);
        @(negedge clk);
        check("t4b_id_error", id_error, 1);
        check("t4b_frame_valid", frame_valid, 0);
        check("t4b_good_frames", good_frames, 2);
        repeat (2) @(negedge clk);

        // Byte landing in the CHECK cycle seeds the next hunt
        fv0 = fv_cnt;
        build_frame(8'd3, 8'h00, 32'h0000_0333, 32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 8'h00);
        send_bytes(0, 29, 0);
        send_byte(8'h1C, 2);
        build_frame(8'd3, 8'h00, 32'h0000_0444, 32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 8'h00);
        send_bytes(1, 29, 0);
        @(negedge clk);
        check("tc_frame_valid", frame_valid, 1);
        check("tc_enc0_pos", encoder0_position, 32'h0000_0444);
        repeat (2) @(negedge clk);
        check("tc_fv_count", fv_cnt - fv0, 2);
        check("tc_good_frames", good_frames, 4);

        // 5: reset after 10 body bytes
        expected_motor = 8'd2;
        build_frame(8'd2, 8'h05, 32'h0000_1234, 32'h0, 32'h0, 32'hFFFF_FFFE,
                    16'h0100, 16'h0000, 16'h0000, 8'h00);
        send_bytes(0, 13, 2);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_good_frames", good_frames, 0);
        check("t5_rst_motor_id", motor_id, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        fv0 = fv_cnt; ce0 = ce_cnt; ie0 = ie_cnt;
        send_bytes(0, 29, 0);
        @(negedge clk);
        check("t5_frame_valid", frame_valid, 1);
        check("t5_motor_id", motor_id, 2);
        check("t5_good_frames", good_frames, 1);
        repeat (2) @(negedge clk);
        check("t5_strobe_counts", {fv_cnt - fv0, ce_cnt - ce0, ie_cnt - ie0}, {32'd1, 32'd0, 32'd0});

        // 6: stall after 12 body bytes for 5 byte times
        build_frame(8'd2, 8'h00, 32'h0000_5555, 32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 8'h00);
        send_bytes(0, 15, 0);
`ifdef STATUS_PARSER_TIMEOUT_EN
        waited = 0;
        while (!timeout_error && waited < 25000) begin
            @(negedge clk);
            waited++;
        end
        check("t6_timeout_seen", timeout_error, 1);
        check("t6_timeout_cycles", waited, GAP_CYCLES + 1);
        @(negedge clk);
        check("t6_timeout_one_cycle", timeout_error, 0);
        send_bytes(0, 29, 0);
`else
        waited = 0;
        repeat (21700) begin
            @(negedge clk);
            waited++;
        end
        check("t6_no_timeout", te_cnt, 0);
        check("t6_idle_no_fv", frame_valid, 0);
        send_bytes(16, 29, 0);
`endif
        @(negedge clk);
        check("t6_frame_valid", frame_valid, 1);
        check("t6_enc0_pos", encoder0_position, 32'h0000_5555);
        check("t6_good_frames", good_frames, 2);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
